// File: rtl/weight_loader_param_3.sv
// ---------------------------------------------------------------------------
// weight_loader_param_3
//
// Write-side companion to the layer-3 weight address generator. Takes a serial
// stream of weight words over a valid/ready handshake, pairs consecutive words
// and writes each pair into the dual-port weight RAM in one cycle: even word on
// port A, odd word on port B. Addresses follow the reader's layout:
//   addra = pair_offset + num_multcomp * NUM_ONE_PIXEL_CYCLE * 2, addrb = addra + 1
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_ready is a function of state only (high in LOAD_EVEN / LOAD_ODD) and never
// looks at in_valid. A source presenting in_valid while in_ready is low must
// hold the word until it is accepted.
//
// Optional build macro: WLOAD_CHECKSUM_EN
//   defined   - checksum is the mod 2^DATA_WIDTH sum of every accepted word,
//               cleared on start and reset, stable while done is high.
//   undefined - no accumulator; checksum is tied to 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   one-cycle pulse, begins a load from IDLE or DONE
//   in_valid   in   in_data valid
//   in_data    in   weight word (DATA_WIDTH)
//   in_ready   out  word accepted this cycle when in_valid is also high
//   wea/web    out  port A/B write strobes (one cycle per pair)
//   addra/addrb out port A (even) / port B (odd) address
//   dina/dinb  out  port A/B write data
//   busy       out  high in LOAD_EVEN / LOAD_ODD
//   done       out  high in DONE
//   checksum   out  see macro note above
//   state_dbg  out  current FSM state (IDLE=0, LOAD_EVEN=1, LOAD_ODD=2, DONE=3)
// ---------------------------------------------------------------------------
module weight_loader_param_3 #(
    parameter int DATA_WIDTH            = 16,
    parameter int WEIGHT_ADDR_WIDTH     = 10,
    parameter int NUM_ONE_PIXEL_CYCLE   = 26,
    parameter int NUM_ONEMULT           = 2,
    parameter int NUM_MULTCOMP_BITWIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         wea,
    output logic                         web,
    output logic [WEIGHT_ADDR_WIDTH-1:0] addra,
    output logic [WEIGHT_ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0]        dina,
    output logic [DATA_WIDTH-1:0]        dinb,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_WIDTH-1:0]        checksum,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_EVEN = 2'd1,
        LOAD_ODD  = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int AW = WEIGHT_ADDR_WIDTH;
    localparam int NB = NUM_MULTCOMP_BITWIDTH;

    localparam logic [AW-1:0] BLOCK_WORDS = AW'(NUM_ONE_PIXEL_CYCLE * 2);
    localparam logic [AW-1:0] LAST_OFFSET = AW'(NUM_ONE_PIXEL_CYCLE * 2 - 2);
    localparam logic [NB-1:0] LAST_BLOCK  = NB'(NUM_ONEMULT - 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           pair_offset_q, pair_offset_d;
    logic [NB-1:0]           num_multcomp_q, num_multcomp_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    strobe_q, strobe_d;
    logic [AW-1:0]           addra_q, addra_d;
    logic [AW-1:0]           addrb_q, addrb_d;
    logic [DATA_WIDTH-1:0]   dina_q, dina_d;
    logic [DATA_WIDTH-1:0]   dinb_q, dinb_d;

    logic                    accept;
    logic                    load_start;
    logic [AW-1:0]           wr_addr;

    assign accept     = in_valid && in_ready;
    // start only has an effect from the two parked states.
    assign load_start = start && ((state_q == IDLE) || (state_q == DONE));
    assign wr_addr    = pair_offset_q + (AW'(num_multcomp_q) * BLOCK_WORDS);

    // ---------------------------------------------------------------------
    // State / datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            pair_offset_q  <= '0;
            num_multcomp_q <= '0;
            hold_q         <= '0;
            strobe_q       <= 1'b0;
            addra_q        <= '0;
            addrb_q        <= AW'(1);
            dina_q         <= '0;
            dinb_q         <= '0;
        end else begin
            state_q        <= state_d;
            pair_offset_q  <= pair_offset_d;
            num_multcomp_q <= num_multcomp_d;
            hold_q         <= hold_d;
            strobe_q       <= strobe_d;
            addra_q        <= addra_d;
            addrb_q        <= addrb_d;
            dina_q         <= dina_d;
            dinb_q         <= dinb_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pair_offset_d  = pair_offset_q;
        num_multcomp_d = num_multcomp_q;
        hold_d         = hold_q;
        strobe_d       = 1'b0;
        addra_d        = addra_q;
        addrb_d        = addrb_q;
        dina_d         = dina_q;
        dinb_d         = dinb_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d        = LOAD_EVEN;
                    pair_offset_d  = '0;
                    num_multcomp_d = '0;
                end
            end
            LOAD_EVEN: begin
                if (accept) begin
                    hold_d  = in_data;
                    state_d = LOAD_ODD;
                end
            end
            LOAD_ODD: begin
                if (accept) begin
                    // Pair is complete: register the write so strobe, address
                    // and data all appear together on the following cycle.
                    strobe_d = 1'b1;
                    addra_d  = wr_addr;
                    addrb_d  = wr_addr + AW'(1);
                    dina_d   = hold_q;
                    dinb_d   = in_data;
                    if (pair_offset_q < LAST_OFFSET) begin
                        pair_offset_d = pair_offset_q + AW'(2);
                        state_d       = LOAD_EVEN;
                    end else if (num_multcomp_q < LAST_BLOCK) begin
                        pair_offset_d  = '0;
                        num_multcomp_d = num_multcomp_q + NB'(1);
                        state_d        = LOAD_EVEN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == LOAD_EVEN) || (state_q == LOAD_ODD);
        busy      = (state_q == LOAD_EVEN) || (state_q == LOAD_ODD);
        done      = (state_q == DONE);
        state_dbg = state_q;
    end

    assign wea   = strobe_q;
    assign web   = strobe_q;
    assign addra = addra_q;
    assign addrb = addrb_q;
    assign dina  = dina_q;
    assign dinb  = dinb_q;

`ifdef WLOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (load_start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q + in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    // Accumulator not built; load_start only feeds it.
    logic unused_load_start;
    assign unused_load_start = load_start;
    assign checksum          = '0;
`endif

endmodule

// File: tb/tb_weight_loader_param_3.sv
module tb_weight_loader_param_3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int NPC = 26;
  localparam int NOM = 2;
  localparam int TOTAL = 2 * NPC * NOM;
  localparam int EW = 2 * AW + 2 * DW + 1;

  logic clk;
  logic reset;
  logic start;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic in_ready, wea, web, busy, done;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb, checksum;
  logic [1:0] state_dbg;

  logic start2;
  logic in_valid2;
  logic [DW-1:0] in_data2;
  logic in_ready2, wea2, web2, busy2, done2;
  logic [AW-1:0] addra2, addrb2;
  logic [DW-1:0] dina2, dinb2, checksum2;
  logic [1:0] state_dbg2;

  int tests_run = 0;
  int tests_failed = 0;

  // scoreboard: {addra, dina, addrb, dinb, is_last}
  logic [EW-1:0] exp_q[$];
  int exp_k;
  logic [DW-1:0] exp_hold;
  logic [DW-1:0] exp_sum;
  int cyc = 0;
  int last_strobe_cyc = -1;
  bit check_gap = 0;

  weight_loader_param_3 #(
    .DATA_WIDTH(DW), .WEIGHT_ADDR_WIDTH(AW), .NUM_ONE_PIXEL_CYCLE(NPC),
    .NUM_ONEMULT(NOM), .NUM_MULTCOMP_BITWIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wea(wea), .web(web), .addra(addra), .addrb(addrb),
    .dina(dina), .dinb(dinb), .busy(busy), .done(done), .checksum(checksum),
    .state_dbg(state_dbg)
  );

  weight_loader_param_3 #(
    .DATA_WIDTH(DW), .WEIGHT_ADDR_WIDTH(AW), .NUM_ONE_PIXEL_CYCLE(1),
    .NUM_ONEMULT(1), .NUM_MULTCOMP_BITWIDTH(2)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .wea(wea2), .web(web2), .addra(addra2), .addrb(addrb2),
    .dina(dina2), .dinb(dinb2), .busy(busy2), .done(done2), .checksum(checksum2),
    .state_dbg(state_dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] exp_checksum();
`ifdef WLOAD_CHECKSUM_EN
    return exp_sum;
`else
    return '0;
`endif
  endfunction

  // write monitor: every strobe must match the next scoreboard entry
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int gap;
    if (!reset && (wea || web)) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_strobe: wea=%b web=%b addra=%0d dina=%0d, required no write", wea, web, addra, dina);
      end else begin
        e = exp_q.pop_front();
        if ({wea, web, addra, dina, addrb, dinb, done} !== {2'b11, e}) begin
          tests_failed++;
          $display("FAIL write: got we=%b%b a=%0d da=%0d b=%0d db=%0d done=%b, required we=11 a=%0d da=%0d b=%0d db=%0d done=%b",
                   wea, web, addra, dina, addrb, dinb, done,
                   e[EW-1 -: AW], e[EW-AW-1 -: DW], e[2*DW+AW : 2*DW+1], e[DW : 1], e[0]);
        end
      end
      if (last_strobe_cyc >= 0) begin
        gap = cyc - last_strobe_cyc;
        tests_run++;
        if (gap < 2 || (check_gap && gap != 2)) begin
          tests_failed++;
          $display("FAIL strobe_gap: got %0d cycles, required %s", gap, check_gap ? "2" : ">=2");
        end
      end
      last_strobe_cyc = cyc;
    end
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    exp_k = 0;
    exp_hold = '0;
    exp_sum = '0;
    last_strobe_cyc = -1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives n words first, first+1, ...; pulses start alongside word glitch_at.
  task automatic drive_words(input int n, input int first, input bit bubbles, input int glitch_at);
    int sent = 0;
    int cycles = 0;
    logic [AW-1:0] a;
    while (sent < n && cycles < 2000) begin
      if (cycles > 0) @(negedge clk);
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = DW'(first + sent);
      start = (sent == glitch_at) && in_valid;
      if (in_valid && in_ready) begin
        exp_sum = exp_sum + in_data;
        if ((exp_k % 2) == 0) begin
          exp_hold = in_data;
        end else begin
          a = AW'(2 * (exp_k / 2));
          exp_q.push_back({a, exp_hold, a + AW'(1), in_data, 1'(exp_k == TOTAL - 1)});
        end
        exp_k++;
        sent++;
      end
      cycles++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    if (sent < n) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drive_timeout: got %0d words accepted, required %0d", sent, n);
    end
  endtask

  // tests
  task automatic test_reset_idle();
    do_reset();
    in_valid = 1'b1;
    in_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if ({in_ready, wea, web, busy, done, addra, addrb, dina, dinb, checksum, state_dbg} !==
          {5'b00000, AW'(0), AW'(1), DW'(0), DW'(0), DW'(0), 2'd0}) begin
        tests_failed++;
        $display("FAIL idle: got rdy=%b we=%b%b busy=%b done=%b a=%0d b=%0d cs=%0d st=%0d, required 0 0 0 0 0 a=0 b=1 cs=0 st=0",
                 in_ready, wea, web, busy, done, addra, addrb, checksum, state_dbg);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_load_end(input string name);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0 || done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || checksum !== exp_checksum()) begin
      tests_failed++;
      $display("FAIL %s_end: got pending=%0d done=%b rdy=%b busy=%b cs=%0d, required pending=0 done=1 rdy=0 busy=0 cs=%0d",
               name, exp_q.size(), done, in_ready, busy, checksum, exp_checksum());
    end
  endtask

  task automatic test_full_load();
    check_gap = 1;
    do_start();
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || checksum !== '0) begin
      tests_failed++;
      $display("FAIL start: got rdy=%b busy=%b cs=%0d, required 1 1 0", in_ready, busy, checksum);
    end
    drive_words(TOTAL, 1, 1'b0, -1);
    check_load_end("full");
`ifdef WLOAD_CHECKSUM_EN
    tests_run++;
    if (checksum !== 16'd5460) begin
      tests_failed++;
      $display("FAIL checksum_const: got %0d, required 5460", checksum);
    end
`endif
    check_gap = 0;
  endtask

  task automatic test_restart_bubbled();
    do_start();
    tests_run++;
    if (done !== 1'b0 || in_ready !== 1'b1 || state_dbg !== 2'd1) begin
      tests_failed++;
      $display("FAIL start_in_done: got done=%b rdy=%b st=%0d, required 0 1 1", done, in_ready, state_dbg);
    end
    drive_words(TOTAL, 1, 1'b1, -1);
    check_load_end("bubbled");
  endtask

  task automatic test_start_ignored();
    check_gap = 1;
    do_start();
    drive_words(TOTAL, 500, 1'b0, 5);
    check_load_end("start_ignored");
    check_gap = 0;
  endtask

  task automatic test_reset_mid_load();
    do_start();
    drive_words(7, 1, 1'b1, -1);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, wea, web, busy, done, addra, addrb, dina, dinb, checksum, state_dbg} !==
        {5'b00000, AW'(0), AW'(1), DW'(0), DW'(0), DW'(0), 2'd0} || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_mid: got rdy=%b we=%b%b busy=%b done=%b a=%0d b=%0d da=%0d db=%0d cs=%0d st=%0d pending=%0d, required reset values, pending=0",
               in_ready, wea, web, busy, done, addra, addrb, dina, dinb, checksum, state_dbg, exp_q.size());
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_gap = 1;
    do_start();
    drive_words(TOTAL, 1000, 1'b0, -1);
    check_load_end("reload");
    check_gap = 0;
  endtask

  task automatic test_param_sweep();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    in_valid2 = 1'b1;
    in_data2 = 16'hAAAA;
    @(negedge clk);
    in_data2 = 16'h5555;
    @(negedge clk);
    in_valid2 = 1'b0;
    tests_run++;
    if ({wea2, web2, addra2, addrb2, dina2, dinb2, done2} !== {2'b11, AW'(0), AW'(1), 16'hAAAA, 16'h5555, 1'b1}) begin
      tests_failed++;
      $display("FAIL sweep_write: got we=%b%b a=%0d b=%0d da=%h db=%h done=%b, required 11 0 1 aaaa 5555 1",
               wea2, web2, addra2, addrb2, dina2, dinb2, done2);
    end
    @(negedge clk);
    tests_run++;
    if ({wea2, web2, done2, in_ready2, busy2} !== 5'b00100) begin
      tests_failed++;
      $display("FAIL sweep_after: got we=%b%b done=%b rdy=%b busy=%b, required 00 1 0 0",
               wea2, web2, done2, in_ready2, busy2);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    start2 = 1'b0;
    in_valid2 = 1'b0;
    in_data2 = '0;
    exp_k = 0;
    exp_hold = '0;
    exp_sum = '0;
    test_reset_idle();
    test_full_load();
    test_restart_bubbled();
    test_start_ignored();
    test_reset_mid_load();
    test_param_sweep();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
